// File: rtl/raabb_result_checker_if.sv
// Expected-result stream between the reference model and the result checker.
// Latency: none, wires only.
// Backpressure: the slave holds exp_ready low to stall the expected stream.
//
// Signals:
//   exp_data  - high-precision expected hit/miss bit
//   exp_valid - exp_data is valid this cycle
//   exp_ready - checker consumes exp_data on an edge where both are high
interface raabb_result_checker_if;
  logic exp_data;
  logic exp_valid;
  logic exp_ready;

  modport master (
    output exp_data,
    output exp_valid,
    input  exp_ready
  );

  modport slave (
    input  exp_data,
    input  exp_valid,
    output exp_ready
  );
endinterface

// File: rtl/raabb_result_checker.sv
// Compares delayed ray/box intersection results against an expected stream.
// Latency: hit_miss sampled LATENCY edges after issue; counters update one edge after handshake.
// Backpressure: exp_ready low when the result FIFO is empty; FIFO overflow drops results (sticky flag).
//
// Ports:
//   clk, rst               - rising-edge clock, asynchronous active-low reset
//   start                  - clears the checker and begins a run
//   issue, hit_miss        - test issued into the pipeline / pipeline result
//   exp (slave modport)    - expected result stream exp_data/exp_valid/exp_ready
//   type1_err, type2_err   - saturating missed-hit / false-hit counts
//   checked, done          - comparisons completed / run complete
//   overflow               - sticky: a result was dropped on a full FIFO
//   first_err_vld/_idx     - first mismatch index of the run
// Optional feature: define RAABB_FIRST_ERR_CAPTURE_EN to enable first-mismatch
// capture; otherwise first_err_vld/first_err_idx are tied to 0.
module raabb_result_checker #(
  parameter int LATENCY    = 38,
  parameter int NUM_TESTS  = 10000,
  parameter int FIFO_DEPTH = 4,
  parameter int T1_W       = 10,
  parameter int T2_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  issue,
  input  logic                  hit_miss,
  raabb_result_checker_if.slave exp,
  output logic [T1_W-1:0]       type1_err,
  output logic [T2_W-1:0]       type2_err,
  output logic [15:0]           checked,
  output logic                  done,
  output logic                  overflow,
  output logic                  first_err_vld,
  output logic [15:0]           first_err_idx
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] NUM_TESTS_L = 16'(NUM_TESTS);

  logic [1:0]            state;
  logic [LATENCY-1:0]    dly;
  logic [LATENCY:0]      dly_shift;
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [FIFO_DEPTH-1:0] mem;

  logic run;
  logic issue_acc;
  logic push;
  logic push_ok;
  logic pop;
  logic full;
  logic empty;
  logic head;
  logic is_t1;
  logic is_t2;

  assign run       = (state == RUN);
  // Issue is only tracked in RUN; a start cycle flushes instead of shifting.
  assign issue_acc = run & issue & ~start;
  assign dly_shift = {dly, issue_acc};
  assign push      = dly[LATENCY-1] & ~start;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Gated by start so the source never sees a handshake that the clear discards.
  assign exp.exp_ready = run & ~empty & ~start;
  assign pop           = exp.exp_valid & exp.exp_ready;
  // On a full FIFO a push is only accepted if the head leaves in the same edge.
  assign push_ok       = push & (~full | pop);

  assign head  = mem[rd_ptr[AW-1:0]];
  assign is_t1 = pop &  exp.exp_data & ~head;
  assign is_t2 = pop & ~exp.exp_data &  head;

  assign done = (state == DONE);

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= hit_miss;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dly       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      type1_err <= '0;
      type2_err <= '0;
      checked   <= '0;
      overflow  <= 1'b0;
    end else if (start) begin
      state     <= RUN;
      dly       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      type1_err <= '0;
      type2_err <= '0;
      checked   <= '0;
      overflow  <= 1'b0;
    end else begin
      dly <= dly_shift[LATENCY-1:0];

      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end

      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        checked <= checked + 16'd1;
        if (is_t1 && (type1_err != {T1_W{1'b1}})) begin
          type1_err <= type1_err + T1_W'(1);
        end
        if (is_t2 && (type2_err != {T2_W{1'b1}})) begin
          type2_err <= type2_err + T2_W'(1);
        end
        if (checked + 16'd1 == NUM_TESTS_L) begin
          state <= DONE;
        end
      end
    end
  end

`ifdef RAABB_FIRST_ERR_CAPTURE_EN
  // checked still holds the pre-increment count, i.e. the 0-based test index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else if (start) begin
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else if ((is_t1 || is_t2) && !first_err_vld) begin
      first_err_vld <= 1'b1;
      first_err_idx <= checked;
    end
  end
`else
  assign first_err_vld = 1'b0;
  assign first_err_idx = 16'd0;
`endif

endmodule

// File: tb/tb_raabb_result_checker.sv
// Directed self-checking bench for raabb_result_checker.
// Latency: DUT built with LATENCY=4, NUM_TESTS=10, FIFO_DEPTH=4, T1_W=2.
// Backpressure: exp_valid is held low in the overflow scenarios.
module tb_raabb_result_checker;
  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        issue;
  logic        hit_miss;
  logic [1:0]  type1_err;
  logic [15:0] type2_err;
  logic [15:0] checked;
  logic        done;
  logic        overflow;
  logic        first_err_vld;
  logic [15:0] first_err_idx;

  int checks = 0;
  int errors = 0;

  raabb_result_checker_if exp_if ();

  raabb_result_checker #(
    .LATENCY(LAT), .NUM_TESTS(10), .FIFO_DEPTH(4), .T1_W(2), .T2_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .issue(issue), .hit_miss(hit_miss),
    .exp(exp_if), .type1_err(type1_err), .type2_err(type2_err),
    .checked(checked), .done(done), .overflow(overflow),
    .first_err_vld(first_err_vld), .first_err_idx(first_err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin
      issue = 1'b1;
      cycles(1);
    end
    issue = 1'b0;
  endtask

  // Bounded wait; a timeout shows up as a checked-count mismatch.
  task automatic wait_checked(input string tag, input int target);
    for (int i = 0; i < 200 && int'(checked) < target; i++) cycles(1);
    chk_eq(tag, checked, target);
  endtask

  task automatic burst(input string tag, input int n, input logic hm, input logic ed, input int target);
    hit_miss         = hm;
    exp_if.exp_data  = ed;
    exp_if.exp_valid = 1'b1;
    issue_n(n);
    wait_checked(tag, target);
  endtask

  initial begin
    logic prev_done;
    rst = 1'b0; start = 1'b0; issue = 1'b0; hit_miss = 1'b0;
    exp_if.exp_data = 1'b0; exp_if.exp_valid = 1'b0;
    cycles(2);

    // Reset state
    chk_eq("rst_checked", checked, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_overflow", overflow, 0);
    chk_eq("rst_ready", exp_if.exp_ready, 0);
    rst = 1'b1;
    cycles(1);

    // IDLE ignores issue
    exp_if.exp_valid = 1'b1;
    issue_n(2);
    cycles(LAT + 2);
    chk_eq("idle_ignore_ready", exp_if.exp_ready, 0);
    chk_eq("idle_ignore_checked", checked, 0);

    // Ten matching tests complete the run
    start_pulse();
    chk_eq("a_start_done", done, 0);
    hit_miss = 1'b1; exp_if.exp_data = 1'b1; exp_if.exp_valid = 1'b1;
    issue_n(10);
    prev_done = done;
    for (int i = 0; i < 200 && checked < 16'd10; i++) begin
      prev_done = done;
      cycles(1);
    end
    chk_eq("a_checked", checked, 10);
    chk_eq("a_done_after_last", done, 1);
    chk_eq("a_done_before_last", prev_done, 0);
    chk_eq("a_type1", type1_err, 0);
    chk_eq("a_type2", type2_err, 0);
    chk_eq("a_first_vld", first_err_vld, 0);

    // DONE ignores issue
    issue_n(3);
    cycles(LAT + 3);
    chk_eq("done_ignore_checked", checked, 10);
    chk_eq("done_ignore_ready", exp_if.exp_ready, 0);
    chk_eq("done_hold", done, 1);

    // Type-1 mismatches after two matches, then saturation at 3
    start_pulse();
    chk_eq("b_clr_checked", checked, 0);
    chk_eq("b_clr_done", done, 0);
    burst("b_match_checked", 2, 1'b1, 1'b1, 2);
    burst("b_t1_checked", 3, 1'b0, 1'b1, 5);
    chk_eq("b_type1_3", type1_err, 3);
    chk_eq("b_type2_0", type2_err, 0);
`ifdef RAABB_FIRST_ERR_CAPTURE_EN
    chk_eq("b_first_vld", first_err_vld, 1);
    chk_eq("b_first_idx", first_err_idx, 2);
`else
    chk_eq("b_first_vld_tied", first_err_vld, 0);
    chk_eq("b_first_idx_tied", first_err_idx, 0);
`endif
    burst("b_sat_checked", 2, 1'b0, 1'b1, 7);
    chk_eq("b_type1_sat", type1_err, 3);

    // Asynchronous reset mid-run with results in flight
    hit_miss = 1'b1; exp_if.exp_data = 1'b1;
    issue_n(2);
    #2 rst = 1'b0;
    #1;
    chk_eq("arst_type1", type1_err, 0);
    chk_eq("arst_type2", type2_err, 0);
    chk_eq("arst_checked", checked, 0);
    chk_eq("arst_done", done, 0);
    chk_eq("arst_overflow", overflow, 0);
    chk_eq("arst_ready", exp_if.exp_ready, 0);
    chk_eq("arst_first_vld", first_err_vld, 0);
    chk_eq("arst_first_idx", first_err_idx, 0);
    cycles(2);
    rst = 1'b1;
    issue_n(2);
    cycles(LAT + 3);
    chk_eq("arst_idle_checked", checked, 0);
    chk_eq("arst_idle_ready", exp_if.exp_ready, 0);

    // Type-2 mismatches in a fresh run
    start_pulse();
    burst("c_checked", 2, 1'b1, 1'b0, 2);
    chk_eq("c_type2", type2_err, 2);
    chk_eq("c_type1", type1_err, 0);
`ifdef RAABB_FIRST_ERR_CAPTURE_EN
    chk_eq("c_first_vld", first_err_vld, 1);
    chk_eq("c_first_idx", first_err_idx, 0);
`endif

    // Overflow: five pushes into a four-entry FIFO with no consumer
    exp_if.exp_valid = 1'b0;
    start_pulse();
    hit_miss = 1'b1; exp_if.exp_data = 1'b1;
    issue_n(5);
    cycles(LAT - 1);
    chk_eq("ovf_before_5th", overflow, 0);
    chk_eq("ovf_ready_nonempty", exp_if.exp_ready, 1);
    cycles(1);
    chk_eq("ovf_on_5th", overflow, 1);
    exp_if.exp_valid = 1'b1;
    wait_checked("ovf_drain_checked", 4);
    cycles(3);
    chk_eq("ovf_retained", checked, 4);
    chk_eq("ovf_sticky", overflow, 1);
    chk_eq("ovf_ready_empty", exp_if.exp_ready, 0);

    // Push and pop on the same edge with the FIFO full is legal
    exp_if.exp_valid = 1'b0;
    start_pulse();
    chk_eq("sim_clr_ovf", overflow, 0);
    issue_n(5);
    cycles(LAT - 1);
    exp_if.exp_valid = 1'b1;
    cycles(1);
    exp_if.exp_valid = 1'b0;
    chk_eq("sim_no_ovf", overflow, 0);
    chk_eq("sim_one_pop", checked, 1);
    exp_if.exp_valid = 1'b1;
    wait_checked("sim_all_kept", 5);
    chk_eq("sim_no_ovf_end", overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
